fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the main decoder.
- Holds the PC, issues requests to instruction memory over a req/ack handshake, and buffers one fetched instruction with its PC.
- Presents opcode field instr[31:21] to the decoder's 11-bit Op input, with a valid/ready handshake.
- Accepts taken-branch redirects (CBZ/B resolution) and squashes wrong-path fetches.

Parameters:
- N, 64, address/PC width in bits.
- RESET_PC, 64'h0, PC value loaded at reset. Bits [1:0] must be 0.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- imem_req  out  1  fetch request.
- imem_addr  out  N  fetch byte address.
- imem_ack  in  1  response valid; imem_rdata is valid in the same cycle.
- imem_rdata  in  32  fetched instruction word.
- br_taken  in  1  redirect pulse, one cycle.
- br_target  in  N  redirect byte address.
- id_ready  in  1  decode stage accepts the buffered instruction this cycle.
- if_valid  out  1  buffered instruction valid.
- if_pc  out  N  address of the buffered instruction.
- if_instr  out  32  buffered instruction.
- if_opcode  out  11  equals if_instr[31:21]; feeds the decoder Op input.

Behaviour:
- Registers:
  - pc: next fetch address.
  - req_addr: address of a squashed outstanding request.
  - buffer: if_valid, if_pc, if_instr.
  - state.
- Reset (async, reset_n=0):
  - state=BOOT, pc=RESET_PC, req_addr=0.
  - if_valid=0, if_pc=0, if_instr=0, imem_req=0.
  - Any in-flight memory response is ignored after reset.
- States:
  - BOOT: imem_req=0. Next state FETCH unconditionally. br_taken here loads pc.
  - FETCH: imem_req=1, imem_addr=pc.
    - ack, no br_taken: buffer<={1,pc,rdata}; pc<=pc+4; go HOLD.
    - ack with br_taken: drop the response; pc<=br_target; stay FETCH.
    - no ack, br_taken: req_addr<=pc; pc<=br_target; go DISCARD.
  - DISCARD: imem_req=1, imem_addr=req_addr (held stable until ack).
    - ack: drop the response; go FETCH.
    - br_taken: pc<=br_target; stay DISCARD.
  - HOLD: if_valid=1.
    - id_ready=0: imem_req=0; hold everything.
    - id_ready=1, no br_taken: imem_req=1 combinationally, imem_addr=pc.
      - ack: load the buffer with the new instruction; pc+=4; stay HOLD.
      - no ack: if_valid<=0; go FETCH. The request stays asserted.
    - br_taken (regardless of id_ready): if_valid<=0; pc<=br_target; imem_req=0; go FETCH.
- Handshake rules:
  - Once imem_req is asserted, it and imem_addr stay stable until imem_ack.
  - imem_ack without a request is ignored.
- Throughput: 1 instr/cycle with zero-wait memory (ack in the request cycle) and id_ready=1.
- Priority: br_taken beats consumption and capture. A redirected buffer is never presented again.
- Arithmetic:
  - pc+4 wraps modulo 2^N.
  - br_target[1:0] is forced to 2'b00 when loaded.
- if_pc/if_instr hold their values while if_valid=0.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - Adds output stall_cycles, 32 bits. Increments each cycle with if_valid && !id_ready.
  - Adds output squash_count, 16 bits. Increments on each br_taken that drops a valid buffer or an outstanding request.
  - Both saturate at all-ones and reset to 0.
- Undefined: neither port nor its logic exists.

Decomposition:
- Package fetch_pkg:
  - typedef enum fetch_state_t {BOOT, FETCH, DISCARD, HOLD}.
  - constants INSTR_W=32, OPCODE_W=11, OPCODE_LSB=21, PC_INCR=4.
- Sub-module fetch_buffer: the one-entry valid/pc/instr register with load, clear and hold controls.
- fetch_stage keeps the FSM, pc and req_addr.

Test Plan:
- Reset release, ack in the same cycle, id_ready=1 → addrs 0,4,8 on consecutive cycles. if_opcode of word 32'hF8400000 reads 11'h7C2.
- id_ready=0 for 3 cycles while HOLD → imem_req=0; if_valid/if_pc/if_instr stable; pc=next address.
- Ack delayed 2 cycles, br_taken to 0x100 in the first FETCH cycle → DISCARD keeps imem_addr at the old pc; the response is dropped; the next request goes to 0x100.
- HOLD with id_ready=1 and br_taken to 0x203 in the same cycle → if_valid=0 next cycle; next imem_addr=0x200.
- reset_n pulsed low while in DISCARD → immediate if_valid=0 and imem_req=0; pc=RESET_PC; a late ack is ignored.
- With FETCH_PERF_CNT_EN: 5 stall cycles plus 2 squashes → stall_cycles=5, squash_count=2.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction-fetch stage
//
// Contents:
//   fetch_state_t  : BOOT / FETCH / DISCARD / HOLD
//   INSTR_W        : instruction word width
//   OPCODE_W       : decoder opcode field width
//   OPCODE_LSB     : lowest instruction bit of the opcode field
//   PC_INCR        : sequential fetch stride in bytes
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT,
        FETCH,
        DISCARD,
        HOLD
    } fetch_state_t;

    localparam int INSTR_W    = 32;
    localparam int OPCODE_W   = 11;
    localparam int OPCODE_LSB = 21;
    localparam int PC_INCR    = 4;

endpackage

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - one-entry valid/pc/instr holding register
//
// Ports:
//   clk, reset_n    : clock, asynchronous active-low reset
//   load            : capture load_pc/load_instr and set valid
//   clear           : drop valid; pc/instr keep their values
//   load_pc         : address of the instruction being captured
//   load_instr      : instruction word being captured
//   valid, pc, instr: current contents
// load has priority over clear; with neither asserted the entry holds.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int N = 64
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               load,
    input  logic               clear,
    input  logic [N-1:0]       load_pc,
    input  logic [INSTR_W-1:0] load_instr,
    output logic               valid,
    output logic [N-1:0]       pc,
    output logic [INSTR_W-1:0] instr
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid <= 1'b0;
            pc    <= '0;
            instr <= '0;
        end else if (load) begin
            valid <= 1'b1;
            pc    <= load_pc;
            instr <= load_instr;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch: PC, imem req/ack, one-entry buffer, redirects
//
// Ports:
//   clk, reset_n              : clock, asynchronous active-low reset
//   imem_req/imem_addr        : fetch request and byte address (stable until imem_ack)
//   imem_ack/imem_rdata       : response strobe and instruction word (same cycle)
//   br_taken/br_target        : one-cycle redirect pulse and target (low two bits ignored)
//   id_ready                  : decoder consumes the buffered instruction this cycle
//   if_valid/if_pc/if_instr   : buffered instruction
//   if_opcode                 : if_instr[31:21], decoder Op input
// Optional build macro FETCH_PERF_CNT_EN adds saturating counters:
//   stall_cycles              : cycles with if_valid && !id_ready
//   squash_count              : redirects that dropped a buffer or an outstanding request
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int           N        = 64,
    parameter logic [N-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset_n,
    output logic                imem_req,
    output logic [N-1:0]        imem_addr,
    input  logic                imem_ack,
    input  logic [INSTR_W-1:0]  imem_rdata,
    input  logic                br_taken,
    input  logic [N-1:0]        br_target,
    input  logic                id_ready,
    output logic                if_valid,
    output logic [N-1:0]        if_pc,
    output logic [INSTR_W-1:0]  if_instr,
    output logic [OPCODE_W-1:0] if_opcode
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]         stall_cycles,
    output logic [15:0]         squash_count
`endif
);

    fetch_state_t state;
    logic [N-1:0] pc;
    logic [N-1:0] req_addr;
    logic [N-1:0] pc_next_seq;
    logic [N-1:0] br_aligned;
    logic         buf_load;
    logic         buf_clear;

    assign pc_next_seq = pc + N'(PC_INCR);
    assign br_aligned  = br_target & ~N'(2'b11);

    // A squashed request keeps its original address until the memory
    // acknowledges it; every other request goes to the live pc.
    assign imem_addr = (state == DISCARD) ? req_addr : pc;
    assign if_opcode = if_instr[OPCODE_LSB +: OPCODE_W];

    // Request and buffer controls are combinational so that HOLD can issue
    // the next fetch in the same cycle the decoder drains the buffer.
    always_comb begin
        imem_req  = 1'b0;
        buf_load  = 1'b0;
        buf_clear = 1'b0;
        case (state)
            FETCH: begin
                imem_req = 1'b1;
                buf_load = imem_ack && !br_taken;
            end
            DISCARD: begin
                imem_req = 1'b1;
            end
            HOLD: begin
                if (br_taken) begin
                    buf_clear = 1'b1;
                end else if (id_ready) begin
                    imem_req = 1'b1;
                    if (imem_ack) begin
                        buf_load = 1'b1;
                    end else begin
                        buf_clear = 1'b1;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= BOOT;
            pc       <= RESET_PC;
            req_addr <= '0;
        end else begin
            case (state)
                BOOT: begin
                    if (br_taken) begin
                        pc <= br_aligned;
                    end
                    state <= FETCH;
                end
                FETCH: begin
                    if (br_taken) begin
                        pc <= br_aligned;
                        // Without an ack the request is still in flight and
                        // must be retired at its old address before refetching.
                        if (!imem_ack) begin
                            req_addr <= pc;
                            state    <= DISCARD;
                        end
                    end else if (imem_ack) begin
                        pc    <= pc_next_seq;
                        state <= HOLD;
                    end
                end
                DISCARD: begin
                    if (br_taken) begin
                        pc <= br_aligned;
                    end
                    if (imem_ack) begin
                        state <= FETCH;
                    end
                end
                HOLD: begin
                    if (br_taken) begin
                        pc    <= br_aligned;
                        state <= FETCH;
                    end else if (id_ready) begin
                        if (imem_ack) begin
                            pc <= pc_next_seq;
                        end else begin
                            state <= FETCH;
                        end
                    end
                end
                default: begin
                    state <= BOOT;
                end
            endcase
        end
    end

    fetch_buffer #(
        .N(N)
    ) u_buffer (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (buf_load),
        .clear      (buf_clear),
        .load_pc    (pc),
        .load_instr (imem_rdata),
        .valid      (if_valid),
        .pc         (if_pc),
        .instr      (if_instr)
    );

`ifdef FETCH_PERF_CNT_EN
    // In FETCH a request is always outstanding; in HOLD the buffer is always
    // valid. A redirect in DISCARD drops nothing new.
    logic squash_event;
    assign squash_event = br_taken && ((state == FETCH) || (state == HOLD));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cycles <= '0;
            squash_count <= '0;
        end else begin
            if (if_valid && !id_ready && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (squash_event && (squash_count != '1)) begin
                squash_count <= squash_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

    localparam logic [31:0] W0   = 32'hF840_0000;
    localparam logic [31:0] W1   = 32'h8B02_0020;
    localparam logic [31:0] W2   = 32'hB400_0040;
    localparam logic [31:0] W3   = 32'h17FF_FFFF;
    localparam logic [31:0] W4   = 32'hCB03_0041;
    localparam logic [31:0] W5   = 32'hD100_0421;
    localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

    logic        clk;
    logic        reset_n;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        br_taken;
    logic [63:0] br_target;
    logic        id_ready;
    logic        if_valid;
    logic [63:0] if_pc;
    logic [31:0] if_instr;
    logic [10:0] if_opcode;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cycles;
    logic [15:0] squash_count;
`endif

    int n_checks;
    int n_fail;

    fetch_stage #(
        .N        (64),
        .RESET_PC (64'h0)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .br_taken     (br_taken),
        .br_target    (br_target),
        .id_ready     (id_ready),
        .if_valid     (if_valid),
        .if_pc        (if_pc),
        .if_instr     (if_instr),
        .if_opcode    (if_opcode)
`ifdef FETCH_PERF_CNT_EN
        ,
        .stall_cycles (stall_cycles),
        .squash_count (squash_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs at the falling edge, then settle before checks.
    task automatic cyc(input logic ack, input logic [31:0] rdata, input logic rdy,
                       input logic br, input logic [63:0] tgt);
        @(negedge clk);
        imem_ack   = ack;
        imem_rdata = rdata;
        id_ready   = rdy;
        br_taken   = br;
        br_target  = tgt;
        #1;
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        reset_n    = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = '0;
        id_ready   = 1'b0;
        br_taken   = 1'b0;
        br_target  = '0;
        #1;
        check("rst_valid", 64'(if_valid), 64'd0);
        check("rst_req",   64'(imem_req), 64'd0);
        check("rst_pc",    if_pc, 64'd0);
        check("rst_instr", 64'(if_instr), 64'd0);
        check("rst_addr",  imem_addr, 64'd0);
`ifdef FETCH_PERF_CNT_EN
        check("rst_stall",  64'(stall_cycles), 64'd0);
        check("rst_squash", 64'(squash_count), 64'd0);
`endif

        cyc(1'b0, '0, 1'b1, 1'b0, '0);
        reset_n = 1'b1;
        check("boot_req", 64'(imem_req), 64'd0);

        // Zero-wait streaming: addresses 0, 4, 8 back to back
        cyc(1'b1, W0, 1'b1, 1'b0, '0);
        check("s0_req",   64'(imem_req), 64'd1);
        check("s0_addr",  imem_addr, 64'h0);
        check("s0_valid", 64'(if_valid), 64'd0);

        cyc(1'b1, W1, 1'b1, 1'b0, '0);
        check("s1_valid",  64'(if_valid), 64'd1);
        check("s1_pc",     if_pc, 64'h0);
        check("s1_instr",  64'(if_instr), 64'(W0));
        check("s1_opcode", 64'(if_opcode), 64'h7C2);
        check("s1_addr",   imem_addr, 64'h4);
        check("s1_req",    64'(imem_req), 64'd1);

        cyc(1'b1, W2, 1'b1, 1'b0, '0);
        check("s2_pc",    if_pc, 64'h4);
        check("s2_instr", 64'(if_instr), 64'(W1));
        check("s2_addr",  imem_addr, 64'h8);

        // Decoder stalls; a stray ack while no request is up must be ignored
        for (int i = 0; i < 5; i++) begin
            cyc(i == 1, JUNK, 1'b0, 1'b0, '0);
            check("stall_req",   64'(imem_req), 64'd0);
            check("stall_valid", 64'(if_valid), 64'd1);
            check("stall_pc",    if_pc, 64'h8);
            check("stall_instr", 64'(if_instr), 64'(W2));
            check("stall_addr",  imem_addr, 64'hC);
        end

        // Drain without an ack: request rises and carries over into FETCH
        cyc(1'b0, '0, 1'b1, 1'b0, '0);
        check("drain_req",  64'(imem_req), 64'd1);
        check("drain_addr", imem_addr, 64'hC);
        check("drain_pc",   if_pc, 64'h8);
`ifdef FETCH_PERF_CNT_EN
        check("perf_stall", 64'(stall_cycles), 64'd5);
`endif

        cyc(1'b1, W3, 1'b1, 1'b0, '0);
        check("refetch_valid", 64'(if_valid), 64'd0);
        check("refetch_pc",    if_pc, 64'h8);
        check("refetch_req",   64'(imem_req), 64'd1);
        check("refetch_addr",  imem_addr, 64'hC);

        // Redirect while HOLD and id_ready: buffer dropped, target aligned
        cyc(1'b0, '0, 1'b1, 1'b1, 64'h203);
        check("hbr_valid",  64'(if_valid), 64'd1);
        check("hbr_pc",     if_pc, 64'hC);
        check("hbr_opcode", 64'(if_opcode), 64'h0BF);
        check("hbr_req",    64'(imem_req), 64'd0);

        // First FETCH after redirect; redirect again with no ack -> DISCARD
        cyc(1'b0, '0, 1'b1, 1'b1, 64'h100);
        check("hbr_valid_after", 64'(if_valid), 64'd0);
        check("hbr_addr_after",  imem_addr, 64'h200);
        check("fbr_req",         64'(imem_req), 64'd1);

        cyc(1'b0, '0, 1'b1, 1'b0, '0);
        check("disc0_addr", imem_addr, 64'h200);
        check("disc0_req",  64'(imem_req), 64'd1);
`ifdef FETCH_PERF_CNT_EN
        check("perf_squash", 64'(squash_count), 64'd2);
`endif

        cyc(1'b1, JUNK, 1'b1, 1'b0, '0);
        check("disc1_addr", imem_addr, 64'h200);
        check("disc1_req",  64'(imem_req), 64'd1);

        cyc(1'b1, W4, 1'b1, 1'b0, '0);
        check("disc_drop_valid", 64'(if_valid), 64'd0);
        check("disc_drop_pc",    if_pc, 64'hC);
        check("post_disc_addr",  imem_addr, 64'h100);
        check("post_disc_req",   64'(imem_req), 64'd1);

        cyc(1'b0, '0, 1'b1, 1'b1, 64'h300);
        check("tgt_valid", 64'(if_valid), 64'd1);
        check("tgt_pc",    if_pc, 64'h100);
        check("tgt_instr", 64'(if_instr), 64'(W4));

        cyc(1'b0, '0, 1'b1, 1'b1, 64'h400);
        check("l_addr", imem_addr, 64'h300);

        // Reset asserted mid-cycle while in DISCARD with an ack pending
        cyc(1'b1, JUNK, 1'b1, 1'b0, '0);
        check("m_addr", imem_addr, 64'h300);
        check("m_req",  64'(imem_req), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_valid", 64'(if_valid), 64'd0);
        check("arst_req",   64'(imem_req), 64'd0);
        check("arst_addr",  imem_addr, 64'h0);
        check("arst_pc",    if_pc, 64'h0);
`ifdef FETCH_PERF_CNT_EN
        check("arst_squash", 64'(squash_count), 64'd0);
`endif

        // Release with the late ack still high; redirect in BOOT near the top
        cyc(1'b1, JUNK, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        reset_n = 1'b1;
        check("late_boot_req",   64'(imem_req), 64'd0);
        check("late_boot_valid", 64'(if_valid), 64'd0);

        cyc(1'b1, W5, 1'b1, 1'b0, '0);
        check("late_ignored", 64'(if_valid), 64'd0);
        check("boot_br_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        check("top_req",      64'(imem_req), 64'd1);

        cyc(1'b0, '0, 1'b1, 1'b0, '0);
        check("wrap_pc",    if_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        check("wrap_instr", 64'(if_instr), 64'(W5));
        check("wrap_addr",  imem_addr, 64'h0);
        check("wrap_req",   64'(imem_req), 64'd1);

        cyc(1'b0, '0, 1'b1, 1'b0, '0);
        check("end_valid", 64'(if_valid), 64'd0);
        check("end_addr",  imem_addr, 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
